mdu_seq_ctrl: RTL and testbench
===============================

// Module: mdu_seq_ctrl
// PURPOSE
//   Sequencer for the iterative multiply/divide unit and the HI/LO register pair.
//   Accepts MULT/MULTU/DIV/DIVU from EX and runs one radix-2 step per cycle.
//   Steps are shift-add for multiply and restoring shift-subtract for divide.
//   Holds results in HI/LO, applies MTHI/MTLO writes, and stalls MFHI/MFLO reads while busy.
// PARAMETERS
//   WIDTH   32   operand / HI / LO width
//   CNT_W   6    iteration counter width; must satisfy 2^CNT_W > WIDTH
// PORTS
//   clk      in   1      system clock; all state updates on rising edge
//   rst_n    in   1      asynchronous, active-low reset
//   start    in   1      launch operation; sampled only in IDLE
//   op       in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   op_a     in   WIDTH  rs operand (multiplicand / dividend)
//   op_b     in   WIDTH  rt operand (multiplier / divisor)
//   flush    in   1      pipeline redirect; abort in-flight operation
//   wr_hi    in   1      MTHI write strobe
//   wr_lo    in   1      MTLO write strobe
//   wdata    in   WIDTH  MTHI/MTLO data
//   rd_hilo  in   1      MFHI/MFLO in EX this cycle
//   busy     out  1      operation in flight (state RUN or FIX)
//   done     out  1      one-cycle pulse; HI/LO updated on the same edge
//   stall    out  1      rd_hilo & busy, combinational
//   hi       out  WIDTH  HI register
//   lo       out  WIDTH  LO register
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, so stall=0.
//   States
//     IDLE -> RUN when start & ~flush. Edge E0 latches op.
//       Signed ops also latch |op_a| and |op_b| plus the result-sign bits.
//     RUN: one step per cycle for WIDTH cycles (counter 0..WIDTH-1), then -> FIX.
//     FIX: applies sign correction, writes hi/lo, pulses done, -> IDLE.
//       MULT: negate 64-bit product if signs differ.
//       DIV: quotient negated if signs differ; remainder takes the dividend's sign.
//   Latency
//     start accepted at E0 -> done=1 and new hi/lo visible after edge E0+WIDTH+1 (33 for WIDTH=32).
//     busy is high from after E0 until that same edge.
//     A new start may be accepted in the cycle done is high, since state is already IDLE.
//   Result mapping
//     MUL: hi = product[63:32], lo = product[31:0].
//     DIV: lo = quotient, hi = remainder.
//   Divide by zero (op_b==0): same latency; lo=all-ones, hi=op_a raw; no sign fix.
//   Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
//   start while busy: ignored; no queueing.
//   flush
//     In RUN/FIX: -> IDLE on the next edge; hi/lo unchanged; no done.
//     flush with start in IDLE: start ignored.
//   MTHI/MTLO
//     Honoured only in IDLE; ignored while busy (EX is stalled anyway).
//     wr in the same IDLE cycle as start: write applied; the result later overwrites it.
//     In the FIX cycle the result wins over any write.
//   stall
//     Purely combinational. Never depends on start in the same cycle.
//     An MF in the cycle after start is therefore stalled.
//   Reset mid-operation: immediate return to IDLE with all outputs at reset values.
// TESTING
//   MULTU 0xFFFFFFFF*0xFFFFFFFF -> done after 33 cycles; hi=0xFFFFFFFE, lo=0x00000001.
//   MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   DIVU 5/0 -> lo=0xFFFFFFFF, hi=0x00000005; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   DIVU 100/7, flush at counter 10 -> busy=0 next cycle, no done, hi/lo keep prior values.
//   MULTU with rd_hilo held high -> stall=1 for all 33 busy cycles, 0 after done.
//     Second start mid-run is ignored.
//   MTHI 0x1234 in IDLE -> hi=0x1234; MTLO during busy -> lo unchanged.
//     rst_n low during RUN -> hi=lo=0, busy=0.

Source files
------------

// File: rtl/mdu_seq_ctrl.sv
// Sequencer for the iterative multiply/divide unit and the HI/LO register pair.
// Latency: start accepted at E0 -> done pulse and new HI/LO after edge E0+WIDTH+1.
// Backpressure: start is ignored while busy; MFHI/MFLO reads see stall=rd_hilo&busy.
module mdu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;   // partial product high half / remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]   b_q, b_d;             // |multiplicand| or |divisor|
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;         // product / quotient sign differs
    logic               rneg_q, rneg_d;       // remainder takes dividend sign
    logic               div0_q, div0_d;       // divisor was zero: quotient keeps all-ones
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand magnitudes and sign bits for signed ops.
    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    assign sgn_a = op[0] & op_a[WIDTH-1];
    assign sgn_b = op[0] & op_b[WIDTH-1];
    assign abs_a = sgn_a ? (~op_a + 1'b1) : op_a;
    assign abs_b = sgn_b ? (~op_b + 1'b1) : op_b;

    // Radix-2 step datapath: shift-add multiply and restoring shift-subtract divide.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff = {1'b0, div_sh} - {2'b00, b_q};
    assign div_ge   = ~div_diff[WIDTH+1];
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;

    // Next-state, datapath step and HI/LO update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start && !flush) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    neg_d    = sgn_a ^ sgn_b;
                    rneg_d   = sgn_a;
                    div0_d   = (op_b == '0);
                    acc_hi_d = '0;
                    if (op[1]) begin
                        acc_lo_d = abs_a;
                        b_d      = abs_b;
                    end else begin
                        acc_lo_d = abs_b;
                        b_d      = abs_a;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Divide by zero skips the quotient fix; the remainder fix
                        // turns |a| back into the raw dividend.
                        lo_d = (neg_q && !div0_q) ? (~acc_lo_q + 1'b1) : acc_lo_q;
                        hi_d = rneg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register file, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = rd_hilo & busy;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed corner cases plus random ops
// compared against a plain-arithmetic reference of MULT/MULTU/DIV/DIVU.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mdu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        rd_hilo = 1'b0;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .rd_hilo(rd_hilo),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: {hi, lo} from the architectural definition of each op.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      p;
        int          sa, sb, q, r;
        logic [63:0] res;
        sa = a;
        sb = b;
        case (o)
            2'b00: res = {32'b0, a} * {32'b0, b};
            2'b01: begin
                p   = longint'(sa) * longint'(sb);
                res = p;
            end
            2'b10: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            default: begin
                if (b == 0)                                       res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r, q};
                end
            end
        endcase
        return res;
    endfunction

    // Launch one op; optionally hold rd_hilo, retry start mid-run, flush, or MTLO while busy.
    // Entered and left at 1 time unit after a rising edge with the DUT idle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input bit rd, input int wr_at);
        int          cyc;
        int          stall_cnt;
        int          dn;
        logic [63:0] r;
        cyc = 0;
        stall_cnt = 0;
        op = o; op_a = a; op_b = b; start = 1'b1; rd_hilo = rd;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && cyc < 60) begin
            if (stall) stall_cnt++;
            if (rd && cyc == 10) begin
                start = 1'b1; op = 2'b10; op_a = $urandom; op_b = 32'd3;
            end
            if (cyc == flush_at) flush = 1'b1;
            if (cyc == wr_at) begin
                wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0; wr_lo = 1'b0;
            cyc++;
            if (wr_at >= 0 && cyc == wr_at + 1) check("mtlo_busy_ignored", {32'b0, lo}, {32'b0, exp_lo});
            if (flush_at >= 0 && cyc == flush_at + 1) break;
        end
        if (flush_at >= 0) begin
            check("flush_busy", {63'b0, busy}, 64'd0);
            check("flush_hilo", {hi, lo}, {exp_hi, exp_lo});
            dn = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) dn++;
                @(posedge clk); #1;
            end
            check("flush_no_done", 64'(dn), 64'd0);
        end else begin
            r = model(o, a, b);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
            check("latency", 64'(cyc), 64'd33);
            check("done", {63'b0, done}, 64'd1);
            check("hilo", {hi, lo}, r);
            check("busy_after", {63'b0, busy}, 64'd0);
            if (rd) begin
                check("stall_cycles", 64'(stall_cnt), 64'd33);
                check("stall_after_done", {63'b0, stall}, 64'd0);
            end
            @(posedge clk); #1;
            check("done_pulse", {63'b0, done}, 64'd0);
        end
        rd_hilo = 1'b0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        // Reset state, with rd_hilo high to show stall stays low.
        rd_hilo = 1'b1;
        #12;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_stall", {63'b0, stall}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_hilo = 1'b0;

        // Directed cases.
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, -1);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, -1, 1'b0, 5);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, -1);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b10, 32'd5, 32'd0, -1, 1'b0, -1);
        check("divu_zero", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, -1);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(2'b11, 32'hFFFF_FFF0, 32'd0, -1, 1'b0, -1);
        run_op(2'b10, 32'd100, 32'd7, 10, 1'b0, -1);

        // MTHI in IDLE.
        wr_hi = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        exp_hi = 32'h0000_1234;
        check("mthi_idle", {32'b0, hi}, 64'h0000_1234);

        // MTLO together with start: write lands, result later overwrites it.
        wr_lo = 1'b1; wdata = 32'h0000_5678;
        op = 2'b00; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        wr_lo = 1'b0; start = 1'b0;
        check("mtlo_with_start", {32'b0, lo}, 64'h0000_5678);
        check("stall_after_start", {63'b0, busy}, 64'd1);
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
        end
        exp_hi = 32'd0; exp_lo = 32'd81;
        check("start_wr_result", {hi, lo}, {exp_hi, exp_lo});

        // Random ops against the reference.
        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = {28'b0, 4'($urandom)};
            run_op(ro, ra, rb, -1, 1'($urandom_range(0, 1)), -1);
        end

        // Asynchronous reset in the middle of RUN.
        op = 2'b10; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_done", {63'b0, done}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_hi = '0; exp_lo = '0;
        run_op(2'b01, 32'd12345, 32'hFFFF_0000, -1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
